// File: rtl/iot_mon_pkg.sv
// Shared types and helpers for the active IoT device monitor.
// Holds the alarm FSM state type, the lane delta width and the saturating adder.
package iot_mon_pkg;

    localparam int LANES_MAX = 16;
    // Sized for the widest lane configuration so every instance can share it.
    localparam int DELTA_W   = $clog2(LANES_MAX + 1) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic [31:0] value;
        logic        ovf;
        logic        unf;
    } sat_res_t;

    // Adds a signed delta to an unsigned count and clamps to [0, 2^width-1].
    function automatic sat_res_t sat_add(input logic [31:0]               count,
                                         input logic signed [DELTA_W-1:0] delta,
                                         input int                        width);
        longint   sum;
        longint   max_v;
        sat_res_t res;
        sum   = longint'(count) + longint'(delta);
        max_v = (longint'(1) <<< width) - 1;
        res   = '0;
        if (sum > max_v) begin
            res.value = 32'(max_v);
            res.ovf   = 1'b1;
        end else if (sum < 0) begin
            res.value = '0;
            res.unf   = 1'b1;
        end else begin
            res.value = 32'(sum);
        end
        return res;
    endfunction

endpackage

// File: rtl/iot_active_monitor_multi_lane_delta_sum.sv
// Net change in active devices for one cycle: on-reports minus off-reports.
// Purely combinational; the result is a signed value in -LANES..+LANES.
module lane_delta_sum
    import iot_mon_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]          change,
    input  logic [LANES-1:0]          on_off,
    output logic signed [DELTA_W-1:0] delta
);

    logic [DELTA_W-1:0] up_cnt;
    logic [DELTA_W-1:0] dn_cnt;

    always_comb begin
        up_cnt = '0;
        dn_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            up_cnt = up_cnt + DELTA_W'(change[i] & on_off[i]);
            dn_cnt = dn_cnt + DELTA_W'(change[i] & ~on_off[i]);
        end
    end

    assign delta = $signed(up_cnt - dn_cnt);

endmodule

// File: rtl/iot_active_monitor_multi.sv
// Multi-lane active device counter with saturation flags, peak tracking
// and a hysteresis alarm driven from the registered count.
module iot_active_monitor_multi
    import iot_mon_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int HI_THRESH = 200,
    parameter int LO_THRESH = 190
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] change,
    input  logic [LANES-1:0] on_off,
    input  logic             clear,
    output logic [WIDTH-1:0] counter_out,
    output logic [WIDTH-1:0] peak_out,
    output logic             alarm,
    output logic             overflow_err,
    output logic             underflow_err
);

    logic signed [DELTA_W-1:0] delta;
    sat_res_t                  sat;
    logic                      unused_sat_hi;

    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             alarm_q;
    mon_state_e       state_q;

    lane_delta_sum #(
        .LANES (LANES)
    ) u_delta (
        .change (change),
        .on_off (on_off),
        .delta  (delta)
    );

    assign sat           = sat_add(32'(counter_q), delta, WIDTH);
    assign unused_sat_hi = ^sat.value[31:WIDTH];

    // A zero delta never lands outside the range, so limits hold without flagging.
    always_comb begin
        counter_d = sat.value[WIDTH-1:0];
        ovf_d     = ovf_q | sat.ovf;
        unf_d     = unf_q | sat.unf;
        peak_d    = (counter_q > peak_q) ? counter_q : peak_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q <= '0;
            peak_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            alarm_q   <= 1'b0;
            state_q   <= IDLE;
        end else if (clear) begin
            counter_q <= '0;
            peak_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            alarm_q   <= 1'b0;
            state_q   <= IDLE;
        end else begin
            counter_q <= counter_d;
            peak_q    <= peak_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            case (state_q)
                IDLE: begin
                    if (counter_q >= WIDTH'(HI_THRESH)) begin
                        state_q <= ALARM;
                        alarm_q <= 1'b1;
                    end
                end
                ALARM: begin
                    if (counter_q <= WIDTH'(LO_THRESH)) begin
                        state_q <= IDLE;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign counter_out   = counter_q;
    assign peak_out      = peak_q;
    assign alarm         = alarm_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule
